// File: rtl/disp_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display.
//   NDIGITS  : number of scanned digits
//   DIG_W    : bits per BCD digit
//   SEG_W    : segment bus width ([6]=a ... [0]=g)
//   AN_OFF   : anode pattern with every digit dark (active-low anodes)
//   BCD_MAX  : largest displayable BCD value; anything above is shown dark
package disp_pkg;

  localparam int unsigned NDIGITS = 4;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned BCD_W   = NDIGITS * DIG_W;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned IDX_W   = $clog2(NDIGITS);

  localparam logic [NDIGITS-1:0] AN_OFF  = '1;
  localparam logic [DIG_W-1:0]   BCD_MAX = DIG_W'(9);

  typedef logic [DIG_W-1:0] digit_t;
  typedef logic [SEG_W-1:0] seg_t;

  // One displayable value: four BCD digits plus its leading-zero option.
  typedef struct packed {
    logic             blank_lz;
    logic [BCD_W-1:0] bcd;
  } disp_val_t;

  // Digits darkened by leading-zero blanking; digit 0 is never blanked.
  function automatic logic [NDIGITS-1:0] lz_mask(input logic [BCD_W-1:0] bcd,
                                                 input logic             en);
    logic [NDIGITS-1:0] m;
    logic               run;
    m   = '0;
    run = en;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      run  = run && (bcd[i*DIG_W +: DIG_W] == '0);
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD to 7-segment decoder, active-high segments, [6]=a ... [0]=g.
//   digit : BCD value 0..15
//   seg_c : segment pattern (combinational); values above 9 decode to all off
module seg_decoder
  import disp_pkg::*;
(
  input  digit_t digit,
  output seg_t   seg_c
);

  always_comb begin
    seg_c = '0;
    case (digit)
      4'd0:    seg_c = 7'b1111110;
      4'd1:    seg_c = 7'b0110000;
      4'd2:    seg_c = 7'b1101101;
      4'd3:    seg_c = 7'b1111001;
      4'd4:    seg_c = 7'b0110011;
      4'd5:    seg_c = 7'b1011011;
      4'd6:    seg_c = 7'b1011111;
      4'd7:    seg_c = 7'b1110000;
      4'd8:    seg_c = 7'b1111111;
      4'd9:    seg_c = 7'b1111011;
      default: seg_c = '0;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// A new value is taken through a valid/ready handshake into a pending slot
// and only promoted to the displayed value at a frame boundary.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bcd_i       : four BCD digits, [3:0] is the rightmost digit
//   blank_lz_i  : leading-zero blanking, captured together with bcd_i
//   valid_i     : a new value is offered
//   ready_o     : pending slot is free
//   an_o        : active-low digit anodes
//   seg_o       : segment pattern of the scanned digit
//   frame_o     : high during the cycle the scan wraps from digit 3 to 0
module display_scan
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BCD_W-1:0]   bcd_i,
  input  logic               blank_lz_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [NDIGITS-1:0] an_o,
  output logic [SEG_W-1:0]   seg_o,
  output logic               frame_o
);

  localparam int unsigned        CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_PRE   = CNT_W'(REFRESH_DIV - 2);
  localparam logic [CNT_W-1:0]   CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NDIGITS - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  disp_val_t          pend_q, pend_d;
  disp_val_t          act_q, act_d;
  logic               ready_d;
  logic [NDIGITS-1:0] an_d;
  seg_t               seg_d;
  logic               frame_d;

  logic               tick;
  logic               wrap;
  digit_t             digs [NDIGITS];
  digit_t             cur_dig;
  logic [NDIGITS-1:0] dark;
  seg_t               seg_c;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // Split the displayed value into digits and flag the ones kept dark.
  always_comb begin
    dark = lz_mask(act_q.bcd, act_q.blank_lz);
    for (int i = 0; i < NDIGITS; i++) begin
      digs[i] = act_q.bcd[i*DIG_W +: DIG_W];
      if (digs[i] > BCD_MAX) dark[i] = 1'b1;
    end
  end

  assign cur_dig = digs[idx_q];

  seg_decoder u_dec (
    .digit (cur_dig),
    .seg_c (seg_c)
  );

  // Next-state: prescaler, digit index, handshake and registered outputs.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    pend_d  = pend_q;
    act_d   = act_q;
    ready_d = ready_o;
    an_d    = AN_OFF;
    seg_d   = seg_c;
    // Registered one cycle early so the pulse lines up with the wrap tick.
    frame_d = (cnt_q == CNT_PRE) && (idx_q == IDX_LAST);

    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // Promotion at the frame boundary wins over a same-cycle offer.
    if (wrap && !ready_o) begin
      act_d   = pend_q;
      ready_d = 1'b1;
    end else if (valid_i && ready_o) begin
      pend_d  = '{blank_lz: blank_lz_i, bcd: bcd_i};
      ready_d = 1'b0;
    end

    if ((cnt_q >= CNT_GUARD) && !dark[idx_q]) an_d = ~(NDIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      ready_o <= 1'b1;
      an_o    <= AN_OFF;
      seg_o   <= '0;
      frame_o <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      ready_o <= ready_d;
      an_o    <= an_d;
      seg_o   <= seg_d;
      frame_o <= frame_d;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=8, GUARD=2 (32-cycle frame).
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_i;
  logic        blank_lz_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_i      (bcd_i),
    .blank_lz_i (blank_lz_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .frame_o    (frame_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  task automatic wait_frame();
    int n = 0;
    while (!frame_o && n < 100) begin
      step();
      n++;
    end
    chk("frame_seen", 32'(frame_o), 32'd1);
  endtask

  task automatic send(input logic [15:0] v, input logic lz);
    int n = 0;
    while (!ready_o && n < 100) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(ready_o), 32'd1);
    bcd_i      = v;
    blank_lz_i = lz;
    valid_i    = 1'b1;
    step();
    valid_i = 1'b0;
    chk("ready_drop", 32'(ready_o), 32'd0);
  endtask

  // Sync to a wrap tick, then check the whole following frame sample by sample.
  task automatic capture(input logic [15:0] val, input logic [3:0] lit,
                         input logic inj, input logic [15:0] inj_val,
                         input logic exp_rw, input logic exp_rn);
    logic [3:0] ea;
    logic [3:0] d;
    int s, p;
    wait_frame();
    chk("ready_at_wrap", 32'(ready_o), 32'(exp_rw));
    if (inj) begin
      bcd_i   = inj_val;
      valid_i = 1'b1;
    end
    step();
    if (inj) valid_i = 1'b0;
    chk("ready_after_wrap", 32'(ready_o), 32'(exp_rn));
    for (int j = 1; j <= 32; j++) begin
      step();
      s  = (j - 1) / 8;
      p  = (j - 1) % 8;
      d  = val[s*4 +: 4];
      ea = (p < 2 || !lit[s]) ? 4'hF : ~(4'b0001 << s);
      chk($sformatf("an v%04h s%0d p%0d", val, s, p), 32'(an_o), 32'(ea));
      chk($sformatf("seg v%04h s%0d p%0d", val, s, p), 32'(seg_o), 32'(seg_of(d)));
      chk($sformatf("frame v%04h j%0d", val, j), 32'(frame_o), 32'(j == 31));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bcd_i      = '0;
    blank_lz_i = 1'b0;
    valid_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_seg", 32'(seg_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_frame", 32'(frame_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(); chk("post_rst_an1", 32'(an_o), 32'hF);
    step(); chk("post_rst_an2", 32'(an_o), 32'hF);
    step(); chk("post_rst_an3", 32'(an_o), 32'hE);
    chk("post_rst_seg3", 32'(seg_o), 32'h7E);

    // Basic scan.
    send(16'h1234, 1'b0);
    capture(16'h1234, 4'hF, 1'b0, 16'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame with a value pending.
    wait_frame();
    repeat (3) step();
    send(16'h5678, 1'b0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an_o), 32'hF);
    chk("async_seg", 32'(seg_o), 32'h0);
    chk("async_ready", 32'(ready_o), 32'd1);
    chk("async_frame", 32'(frame_o), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(); chk("rel_an1", 32'(an_o), 32'hF);
    step(); chk("rel_an2", 32'(an_o), 32'hF);
    step(); chk("rel_an3", 32'(an_o), 32'hE);
    chk("rel_seg3", 32'(seg_o), 32'h7E);
    capture(16'h0000, 4'hF, 1'b0, 16'h0, 1'b1, 1'b1);

    // Tear-free update: second value held on valid_i while pending is full.
    wait_frame();
    repeat (10) step();
    send(16'h1111, 1'b0);
    bcd_i   = 16'h2222;
    valid_i = 1'b1;
    capture(16'h1111, 4'hF, 1'b0, 16'h0, 1'b0, 1'b1);
    valid_i = 1'b0;
    chk("tear_ready_post", 32'(ready_o), 32'd1);
    capture(16'h2222, 4'hF, 1'b0, 16'h0, 1'b1, 1'b1);

    // Leading-zero blanking.
    send(16'h0070, 1'b1);
    capture(16'h0070, 4'b0011, 1'b0, 16'h0, 1'b0, 1'b1);
    send(16'h0000, 1'b1);
    capture(16'h0000, 4'b0001, 1'b0, 16'h0, 1'b0, 1'b1);
    send(16'h0305, 1'b1);
    capture(16'h0305, 4'b0111, 1'b0, 16'h0, 1'b0, 1'b1);

    // Non-BCD digit stays dark.
    send(16'h9A05, 1'b0);
    capture(16'h9A05, 4'b1011, 1'b0, 16'h0, 1'b0, 1'b1);

    // Offer on the wrap tick while pending is full: transfer wins, offer lost.
    send(16'h4321, 1'b0);
    capture(16'h4321, 4'hF, 1'b1, 16'h8765, 1'b0, 1'b1);
    capture(16'h4321, 4'hF, 1'b0, 16'h0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 50000, clock cycles per digit slot (must be at least 4).
REQ-002 SHALL have parameter: GUARD, 2, cycles at the start of each slot with all anodes off (must be less than REFRESH_DIV).
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: bcd_i  input  16  four BCD digits; [3:0] is digit 0 (rightmost).
REQ-006 SHALL have port: blank_lz_i  input  1  leading-zero blanking enable; sampled with bcd_i.
REQ-007 SHALL have port: valid_i  input  1  new value offered.
REQ-008 SHALL have port: ready_o  output  1  block can accept a value.
REQ-009 SHALL have port: an_o  output  4  digit anodes, active-low, one-hot-low or all-high.
REQ-010 SHALL have port: seg_o  output  7  segment pattern, [6]=a ... [0]=g, exactly the decoder's output encoding.
REQ-011 SHALL have port: frame_o  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping; the terminal count is the slot tick.
REQ-013 SHALL advance the digit index 0->1->2->3->0 on each slot tick.
REQ-014 SHALL accept a value on a cycle with valid_i=1 and ready_o=1 into a pending register; ready_o SHALL go low the next cycle.
REQ-015 SHALL ignore valid_i while ready_o=0; the pending value is not overwritten.
REQ-016 SHALL copy pending into the active register only on the tick where the index wraps 3->0, then raise ready_o the next cycle, so a frame never mixes two values.
REQ-017 SHALL assert frame_o for exactly the wrap tick cycle, whether or not an update occurs.
REQ-018 SHALL, when a transfer and an accept coincide on the wrap tick, perform the transfer; the new valid_i is not accepted (ready_o=0 that cycle).
REQ-019 SHALL drive an_o=4'b1111 during the first GUARD cycles of each slot (ghost suppression).
REQ-020 SHALL drive an_o low for the current digit during the remaining cycles of the slot.
REQ-021 SHALL register an_o and seg_o so that they change on the same clock edge; seg_o reflects the current digit with a fixed one-cycle latency relative to the index.
REQ-022 SHALL treat any digit with a BCD value above 9 as blank: its anode stays high for the whole slot.
REQ-023 SHALL, when the active blank_lz is 1, blank digits 3, 2 and 1 from the left while they are 0; digit 0 is never blanked by this rule (value 0 shows "0").

Reset
REQ-024 SHALL, while rst_n=0, hold: an_o=4'b1111, seg_o=7'b0000000, frame_o=0, ready_o=1, prescaler=0, index=0, active=0, pending=0, blank_lz=0.
REQ-025 SHALL abandon any pending value when reset is asserted mid-frame; the first slot after release is digit 0 with full GUARD.

Structure
REQ-026 SHALL place the digit count (4), segment width (7), the all-off anode constant, and the BCD maximum (9) in the shared package disp_pkg.
REQ-027 SHALL instantiate exactly one seg_decoder on the selected 4-bit digit; no segment logic is duplicated inside this module.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-028 SHALL check reset: hold rst_n=0 for 3 cycles mid-scan -> an_o=1111, seg_o=0, ready_o=1 immediately (asynchronous); after release, the first anode low is 1110, at cycle 3.
REQ-029 SHALL check scan: bcd_i=16'h1234 accepted -> after next wrap, per slot an_o = 1110/1101/1011/0111 with seg_o = decoder(4), decoder(3), decoder(2), decoder(1); guard cycles show 1111; frame_o pulses every 32 cycles.
REQ-030 SHALL check tear-free update: accept 16'h1111 mid-frame, then hold valid_i with 16'h2222 -> second value not accepted until ready_o returns; no frame shows mixed digits.
REQ-031 SHALL check blanking: 16'h0070 with blank_lz_i=1 -> digits 3 and 2 are dark, digit 1 is dark only if 0 (here digit 1=7, lit), digit 0 shows 0; 16'h0000 -> only digit 0 lit.
REQ-032 SHALL check invalid BCD: 16'h9A05 -> digit 2 anode stays high for its entire slot; the other digits are lit normally.
REQ-033 SHALL check coincidence: valid_i asserted exactly on the wrap tick while pending is full -> the transfer occurs, the new value is rejected, and ready_o rises one cycle later.
